// File: rtl/ddr_host_arbiter.sv
// NCH-channel valid/ready front end for the dram_controller host port: one access at a time, round-robin grant.
// Define DDR_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins, pointer held at 0).
module ddr_host_arbiter #(
    parameter int NCH = 4,
    parameter int AW  = 23,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req_valid,
    output logic [NCH-1:0]    req_ready,
    input  logic [NCH-1:0]    req_we,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH*DW-1:0] req_wdata,
    output logic [NCH-1:0]    rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              mem_ceb,
    output logic              mem_web,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [2:0]        grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      grant_q, grant_d;
    logic            we_q, we_d;
    logic [NCH-1:0]  req_ready_q, req_ready_d;
    logic [NCH-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            mem_ceb_q, mem_ceb_d;
    logic            mem_web_q, mem_web_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [2:0]      win;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    // First valid channel at or after ptr, wrapping; in fixed-priority builds ptr stays 0.
    always_comb begin
        logic [3:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, ptr_q} + 4'(k);
            if (idx >= 4'(NCH)) idx = idx - 4'(NCH);
            for (int j = 0; j < NCH; j++) begin
                if (!found && req_valid[j] && (4'(j) == idx)) begin
                    found = 1'b1;
                    win   = 3'(j);
                end
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NCH; j++) begin
            if (3'(j) == win) begin
                sel_we    = req_we[j];
                sel_addr  = req_addr[j*AW +: AW];
                sel_wdata = req_wdata[j*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        we_d        = we_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        mem_ceb_d   = mem_ceb_q;
        mem_web_d   = mem_web_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_ready && found) begin
                    grant_d     = win;
                    we_d        = sel_we;
                    mem_ceb_d   = 1'b0;
                    mem_web_d   = ~sel_we;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    for (int j = 0; j < NCH; j++) req_ready_d[j] = (3'(j) == win);
                    state_d     = S_ISSUE;
                end
            end
            // Strobe stays low until the controller acknowledges by dropping ready.
            S_ISSUE: begin
                if (!mem_ready) begin
                    mem_ceb_d = 1'b1;
                    mem_web_d = 1'b1;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ready) begin
                    if (!we_q) rsp_rdata_d = mem_rdata;
                    for (int j = 0; j < NCH; j++) rsp_valid_d[j] = (3'(j) == grant_q);
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
`ifdef DDR_ARB_FIXED_PRIO_EN
                ptr_d = '0;
`else
                ptr_d = (grant_q == 3'(NCH-1)) ? 3'd0 : grant_q + 3'd1;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            we_q        <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            mem_ceb_q   <= 1'b1;
            mem_web_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_ceb_q   <= mem_ceb_d;
            mem_web_q   <= mem_web_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_ceb   = mem_ceb_q;
    assign mem_web   = mem_web_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule
